// File: rtl/posiciones_juego.sv
// Racing game logic: moves the player car from the buttons once per video frame,
// scrolls two enemy cars down fixed lanes, detects crashes and keeps the score.
module posiciones_juego #(
    parameter int unsigned PISTA_MIN      = 160,
    parameter int unsigned PISTA_MAX      = 480,
    parameter int unsigned ANCHO_AUTO     = 32,
    parameter int unsigned ALTO_AUTO      = 48,
    parameter int unsigned JUGADOR_Y      = 400,
    parameter int unsigned CARRIL1_X      = 200,
    parameter int unsigned CARRIL2_X      = 380,
    parameter int unsigned INICIO_JUGADOR = 304,
    parameter int unsigned DESFASE2       = 240,
    parameter int unsigned VEL_JUGADOR    = 4,
    parameter int unsigned VEL_ENEMIGO    = 3,
    parameter int unsigned LIM_Y          = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vsync,
    input  logic        btnIzq,
    input  logic        btnDer,
    input  logic        btnStart,
    output logic [9:0]  posicionJugador,
    output logic [9:0]  posicionEnemigo1,
    output logic [9:0]  posicionEnemigo2,
    output logic        choque,
    output logic [1:0]  estado,
    output logic [15:0] puntaje
);

    typedef enum logic [1:0] {
        ESPERA = 2'b00,
        CORRE  = 2'b01,
        CHOQUE = 2'b10
    } estado_t;

    // All position arithmetic is done one bit wider than the outputs so that
    // sums and differences can never wrap before being clamped.
    localparam logic [10:0] MIN_X   = 11'(PISTA_MIN);
    localparam logic [10:0] MAX_X   = 11'(PISTA_MAX - ANCHO_AUTO);
    localparam logic [10:0] ANCHO   = 11'(ANCHO_AUTO);
    localparam logic [10:0] ALTO    = 11'(ALTO_AUTO);
    localparam logic [10:0] FILA_J  = 11'(JUGADOR_Y);
    localparam logic [10:0] LANE1   = 11'(CARRIL1_X);
    localparam logic [10:0] LANE2   = 11'(CARRIL2_X);
    localparam logic [10:0] VEL_J   = 11'(VEL_JUGADOR);
    localparam logic [10:0] VEL_E   = 11'(VEL_ENEMIGO);
    localparam logic [10:0] LIMITE  = 11'(LIM_Y);
    localparam logic [9:0]  X_INI   = 10'(INICIO_JUGADOR);
    localparam logic [9:0]  Y2_INI  = 10'(DESFASE2);

    logic vsyncMeta, vsyncSync, vsyncPrev;
    logic izqMeta, izqSync;
    logic derMeta, derSync;
    logic startMeta, startSync, startPrev;
    logic tick, start;

    estado_t     estadoActual, estadoSig;
    logic [9:0]  jugadorX, jugadorSig;
    logic [9:0]  enemigo1Y, enemigo1Sig;
    logic [9:0]  enemigo2Y, enemigo2Sig;
    logic [15:0] puntajeReg, puntajeSig;

    logic [10:0] jugadorAncho, jugadorMovido;
    logic [10:0] enemigo1Avance, enemigo2Avance;
    logic        vuelta1, vuelta2;
    logic [16:0] puntajeSuma;
    logic [15:0] puntajeSumado;
    logic        golpe1, golpe2, golpe;

    // The vsync chain resets high so that releasing reset never looks like a
    // falling edge and fakes a frame tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsyncMeta <= 1'b1;
            vsyncSync <= 1'b1;
            vsyncPrev <= 1'b1;
            izqMeta   <= 1'b0;
            izqSync   <= 1'b0;
            derMeta   <= 1'b0;
            derSync   <= 1'b0;
            startMeta <= 1'b0;
            startSync <= 1'b0;
            startPrev <= 1'b0;
            tick      <= 1'b0;
            start     <= 1'b0;
        end else begin
            vsyncMeta <= vsync;
            vsyncSync <= vsyncMeta;
            vsyncPrev <= vsyncSync;
            izqMeta   <= btnIzq;
            izqSync   <= izqMeta;
            derMeta   <= btnDer;
            derSync   <= derMeta;
            startMeta <= btnStart;
            startSync <= startMeta;
            startPrev <= startSync;
            tick      <= vsyncPrev & ~vsyncSync;
            start     <= startSync & ~startPrev;
        end
    end

    always_comb begin
        jugadorAncho  = {1'b0, jugadorX};
        jugadorMovido = jugadorAncho;
        if (izqSync && !derSync) begin
            jugadorMovido = (jugadorAncho < MIN_X + VEL_J) ? MIN_X : jugadorAncho - VEL_J;
        end else if (derSync && !izqSync) begin
            jugadorMovido = (jugadorAncho + VEL_J > MAX_X) ? MAX_X : jugadorAncho + VEL_J;
        end
    end

    // Each enemy that reaches the bottom wraps to the top and counts as one
    // passed car; the score sticks at its maximum instead of rolling over.
    always_comb begin
        enemigo1Avance = {1'b0, enemigo1Y} + VEL_E;
        enemigo2Avance = {1'b0, enemigo2Y} + VEL_E;
        vuelta1        = enemigo1Avance >= LIMITE;
        vuelta2        = enemigo2Avance >= LIMITE;
        puntajeSuma    = {1'b0, puntajeReg} + 17'(vuelta1) + 17'(vuelta2);
        puntajeSumado  = puntajeSuma[16] ? 16'hFFFF : puntajeSuma[15:0];
    end

    always_comb begin
        golpe1 = (jugadorAncho < LANE1 + ANCHO) && (LANE1 < jugadorAncho + ANCHO) &&
                 ({1'b0, enemigo1Y} < FILA_J + ALTO) && (FILA_J < {1'b0, enemigo1Y} + ALTO);
        golpe2 = (jugadorAncho < LANE2 + ANCHO) && (LANE2 < jugadorAncho + ANCHO) &&
                 ({1'b0, enemigo2Y} < FILA_J + ALTO) && (FILA_J < {1'b0, enemigo2Y} + ALTO);
        golpe  = (estadoActual == CORRE) && (golpe1 || golpe2);
    end

    // A crash takes priority over a frame tick arriving on the same cycle, so
    // the positions shown at the moment of the crash are the ones that hit.
    always_comb begin
        estadoSig   = estadoActual;
        jugadorSig  = jugadorX;
        enemigo1Sig = enemigo1Y;
        enemigo2Sig = enemigo2Y;
        puntajeSig  = puntajeReg;
        case (estadoActual)
            ESPERA: begin
                if (start) begin
                    estadoSig  = CORRE;
                    puntajeSig = 16'd0;
                end
            end
            CORRE: begin
                if (golpe) begin
                    estadoSig = CHOQUE;
                end else if (tick) begin
                    jugadorSig  = jugadorMovido[9:0];
                    enemigo1Sig = vuelta1 ? 10'd0 : enemigo1Avance[9:0];
                    enemigo2Sig = vuelta2 ? 10'd0 : enemigo2Avance[9:0];
                    puntajeSig  = puntajeSumado;
                end
            end
            CHOQUE: begin
                if (start) begin
                    estadoSig   = ESPERA;
                    jugadorSig  = X_INI;
                    enemigo1Sig = 10'd0;
                    enemigo2Sig = Y2_INI;
                end
            end
            default: begin
                estadoSig   = ESPERA;
                jugadorSig  = X_INI;
                enemigo1Sig = 10'd0;
                enemigo2Sig = Y2_INI;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estadoActual <= ESPERA;
            jugadorX     <= X_INI;
            enemigo1Y    <= 10'd0;
            enemigo2Y    <= Y2_INI;
            puntajeReg   <= 16'd0;
        end else begin
            estadoActual <= estadoSig;
            jugadorX     <= jugadorSig;
            enemigo1Y    <= enemigo1Sig;
            enemigo2Y    <= enemigo2Sig;
            puntajeReg   <= puntajeSig;
        end
    end

    assign posicionJugador  = jugadorX;
    assign posicionEnemigo1 = enemigo1Y;
    assign posicionEnemigo2 = enemigo2Y;
    assign puntaje          = puntajeReg;
    assign estado           = estadoActual;
    assign choque           = (estadoActual == CHOQUE);

endmodule

// File: doc/posiciones_juego.md
Name: posiciones_juego

Overview:
- Game-logic stage directly upstream of the VGA top; produces posicionJugador, posicionEnemigo1 and posicionEnemigo2.
- Once per video frame (vsync tick) it moves the player car horizontally from buttons and scrolls two enemy cars down fixed lanes.
- Also detects collisions, keeps score, and runs a wait/run/crash game FSM.

Parameters:
PISTA_MIN, 160, leftmost allowed player X (left edge)
PISTA_MAX, 480, track right boundary; player X max = PISTA_MAX-ANCHO_AUTO
ANCHO_AUTO, 32, car width in pixels
ALTO_AUTO, 48, car height in pixels
JUGADOR_Y, 400, fixed top Y of player car
CARRIL1_X, 200, fixed left X of enemy 1 lane
CARRIL2_X, 380, fixed left X of enemy 2 lane
INICIO_JUGADOR, 304, player X after reset/restart
DESFASE2, 240, enemy 2 Y after reset/restart
VEL_JUGADOR, 4, player pixels per frame
VEL_ENEMIGO, 3, enemy pixels per frame
LIM_Y, 480, enemy Y wrap limit

Ports:
clock  input  1  system clock (same clock the VGA top receives)
reset  input  1  asynchronous, active-high reset
vsync  input  1  active-low vsync from the VGA controller, asynchronous to clock
btnIzq  input  1  move-left button, active-high, asynchronous
btnDer  input  1  move-right button, active-high, asynchronous
btnStart  input  1  start/restart button, active-high, asynchronous
posicionJugador  output  10  player car left X
posicionEnemigo1  output  10  enemy 1 top Y (lane CARRIL1_X)
posicionEnemigo2  output  10  enemy 2 top Y (lane CARRIL2_X)
choque  output  1  high while in CHOQUE
estado  output  2  00 ESPERA, 01 CORRE, 10 CHOQUE
puntaje  output  16  enemies passed, saturating

Behaviour:
- Reset (asynchronous, active-high) sets:
  - posicionJugador=INICIO_JUGADOR, posicionEnemigo1=0, posicionEnemigo2=DESFASE2
  - estado=ESPERA, choque=0, puntaje=0
  - all synchronizer and edge flops cleared; vsync sync flops reset to 1.
- Synchronization: vsync, btnIzq, btnDer and btnStart each pass through a 2-flop synchronizer.
- tick: registered 1-cycle pulse on the synced vsync falling edge. It asserts 3 clock cycles after the raw edge.
- start: registered 1-cycle pulse on the synced btnStart rising edge.
- ESPERA:
  - Positions are held at their initial values.
  - start -> CORRE; puntaje cleared to 0 on that same edge.
- CORRE, on each tick (registered outputs update on the clock edge where tick=1):
  - Player: btnIzq only -> X = max(PISTA_MIN, X-VEL_JUGADOR). btnDer only -> X = min(PISTA_MAX-ANCHO_AUTO, X+VEL_JUGADOR). Both or neither -> X unchanged. Compute in 11 bits; no underflow or overflow is permitted.
  - Enemy k: if Y+VEL_ENEMIGO >= LIM_Y, Y=0 and puntaje+1; otherwise Y += VEL_ENEMIGO.
  - Both enemies wrapping on the same tick -> puntaje+2.
  - puntaje saturates at 0xFFFF.
- Collision (combinational, on the registered positions, evaluated every cycle in CORRE):
  - Hit with enemy k when all hold: posicionJugador < CARRILk_X+ANCHO_AUTO, CARRILk_X < posicionJugador+ANCHO_AUTO, posicionEnemigok < JUGADOR_Y+ALTO_AUTO, JUGADOR_Y < posicionEnemigok+ALTO_AUTO.
  - Arithmetic is 11-bit unsigned.
  - Any hit -> next edge estado=CHOQUE, choque=1.
  - If a tick coincides with a hit cycle, the transition wins and positions do not update.
- CHOQUE:
  - Positions and puntaje are frozen; tick is ignored.
  - start -> ESPERA, positions reloaded to reset values; puntaje is held until the next ESPERA->CORRE.
- start pulses in CORRE are ignored. Button levels are used only on tick cycles.
- Reset asserted mid-frame or mid-game returns all state to reset values immediately (asynchronous).
- Latency:
  - raw vsync fall -> position update: 4 clock edges.
  - overlapping positions registered -> choque=1: 1 edge.

Test Plan:
- Apply reset, no input -> posicionJugador=304, posicionEnemigo1=0, posicionEnemigo2=240, estado=00, choque=0, puntaje=0; 10 vsync frames in ESPERA leave all unchanged.
- Start pulse, then 1 frame with no buttons -> estado=01, posicionEnemigo1=3, posicionEnemigo2=243, posicionJugador=304.
- In CORRE, hold btnDer for 50 frames -> posicionJugador climbs by 4 per frame and clamps at 448. Then hold both buttons 5 frames -> remains 448.
- Run from start with the player at 304, no buttons, for 160 frames (enemy 1 reaches 477, then wraps):
  - enemy 1 wraps on frame 160 to 0 and puntaje=1.
  - enemy 2 wraps on frame 80 (240+240=480).
  - expect puntaje=2 total by frame 160.
  - choque stays 0, since player 304..335 overlaps neither lane.
- Hold btnIzq 26 frames (X=200), then let enemy 1 descend -> choque=1 and estado=10 on the first frame where posicionEnemigo1 > 352. Further frames leave all positions frozen. A start pulse then gives estado=00 with initial positions.
- Assert reset asynchronously mid-CORRE between clock edges -> outputs return to reset values before the next clock edge; no tick is generated by the reset release.
